// File: rtl/chn_fifo_bridge_pkg.sv
// chn_fifo_bridge_pkg: shared constants and types for the channel FIFO bridge.
// Holds the destination FSM state encoding, default widths and the bit
// positions of the optional sticky error vector (macro CHN_FIFO_ERR_EN).
package chn_fifo_bridge_pkg;

  localparam int DEF_DW = 64;
  localparam int DEF_AW = 4;
  localparam int DEF_CW = 24;

  typedef enum logic [1:0] {
    DST_IDLE = 2'd0,
    DST_XFER = 2'd1,
    DST_END  = 2'd2
  } dst_state_e;

  localparam int ERR_W       = 4;
  localparam int ERR_SRC_OVF = 0;
  localparam int ERR_SRC_UDF = 1;
  localparam int ERR_DST_OVF = 2;
  localparam int ERR_DST_UDF = 3;

endpackage

// File: rtl/chn_fifo.sv
// chn_fifo: first-word-fall-through FIFO with an explicit occupancy level.
// The head entry is read straight from the read pointer, so a word is visible
// in the same cycle the level becomes non-zero. Storage is not reset; only
// pointers and level are. clr_i is a synchronous clear that beats push/pop.
module chn_fifo #(
  parameter int W  = 65,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_empty_o,
  output logic          almost_full_o
);

  localparam int              DEPTH     = 1 << AW;
  localparam logic [AW:0]     LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]     LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     LVL_AFULL = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0]   PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_s, full_s;
  logic          push_ok_s, pop_ok_s;

  assign empty_s = (level_q == LVL_ZERO);
  assign full_s  = (level_q == LVL_FULL);

  // Decide which requests are accepted and compute next pointers and level.
  always_comb begin
    push_ok_s = push_i & ~full_s & ~clr_i;
    pop_ok_s  = pop_i & ~empty_s & ~clr_i;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (clr_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      level_q  <= LVL_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset because level gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o         = mem_q[rd_ptr_q];
  assign level_o        = level_q;
  assign empty_o        = empty_s;
  assign full_o         = full_s;
  assign almost_empty_o = (level_q <= LVL_ONE);
  assign almost_full_o  = (level_q >= LVL_AFULL);

endmodule

// File: rtl/chn_fifo_bridge.sv
// chn_fifo_bridge: two channel FIFOs between a bus slave and a module.
//  - source FIFO: bus pushes words, module pops them (active-low get).
//  - destination FIFO: module pushes (active-low put), bus pops; a small FSM
//    tracks the destination transfer and stops it on a last flag or when the
//    popped word count reaches dc_i (0 = unlimited).
// Optional feature: define CHN_FIFO_ERR_EN to add sticky err_o[3:0].
module chn_fifo_bridge
  import chn_fifo_bridge_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          m_reset_i,
  input  logic [CW-1:0] dc_i,
  input  logic          ss_xfer_src_i,
  input  logic          ss_last_src_i,
  input  logic [DW-1:0] wbs_dat_src_i,
  output logic          ss_start_src_o,
  output logic          ss_stop_src_o,
  input  logic          m_src_getn_i,
  output logic [DW-1:0] m_src_o,
  output logic          m_src_last_o,
  output logic          m_src_empty_o,
  output logic          m_src_almost_empty_o,
  input  logic          m_dst_putn_i,
  input  logic [DW-1:0] m_dst_i,
  input  logic          m_dst_last_i,
  output logic          m_dst_full_o,
  output logic          m_dst_almost_full_o,
  input  logic          m_endn_i,
  input  logic          ss_xfer_dst_i,
  output logic [DW-1:0] wbs_dat_dst_o,
  output logic          ss_start_dst_o,
  output logic          ss_stop_dst_o,
  output logic          ss_end_dst_o
`ifdef CHN_FIFO_ERR_EN
  ,
  output logic [ERR_W-1:0] err_o
`endif
);

  localparam int            DEPTH  = 1 << AW;
  localparam logic [AW:0]   HALF_L = (AW+1)'(DEPTH / 2);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Source FIFO signals
  logic          src_push_s, src_pop_s;
  logic [DW:0]   src_head_s;
  logic [AW:0]   src_level_s;
  logic          src_empty_s, src_full_s, src_aempty_s, src_afull_s;

  // Destination FIFO signals
  logic          dst_push_s, dst_pop_req_s, dst_pop_ok_s;
  logic [DW:0]   dst_head_s;
  logic [AW:0]   dst_level_s;
  logic          dst_empty_s, dst_full_s, dst_aempty_s, dst_afull_s;

  // Destination FSM state
  dst_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_base_s, cnt_inc_s;
  logic          dc_hit_s;
  logic          end_q, end_d;

  assign src_push_s = ss_xfer_src_i;
  assign src_pop_s  = ~m_src_getn_i;
  assign dst_push_s = ~m_dst_putn_i;
  // Pops are refused once the transfer has ended.
  assign dst_pop_req_s = ss_xfer_dst_i & (state_q != DST_END);
  assign dst_pop_ok_s  = dst_pop_req_s & ~dst_empty_s & ~m_reset_i;

  chn_fifo #(.W(DW + 1), .AW(AW)) u_src_fifo (
    .clk_i          (wb_clk_i),
    .rst_n_i        (wb_rst_n_i),
    .clr_i          (m_reset_i),
    .push_i         (src_push_s),
    .pop_i          (src_pop_s),
    .din_i          ({ss_last_src_i, wbs_dat_src_i}),
    .dout_o         (src_head_s),
    .level_o        (src_level_s),
    .empty_o        (src_empty_s),
    .full_o         (src_full_s),
    .almost_empty_o (src_aempty_s),
    .almost_full_o  (src_afull_s)
  );

  chn_fifo #(.W(DW + 1), .AW(AW)) u_dst_fifo (
    .clk_i          (wb_clk_i),
    .rst_n_i        (wb_rst_n_i),
    .clr_i          (m_reset_i),
    .push_i         (dst_push_s),
    .pop_i          (dst_pop_req_s),
    .din_i          ({m_dst_last_i, m_dst_i}),
    .dout_o         (dst_head_s),
    .level_o        (dst_level_s),
    .empty_o        (dst_empty_s),
    .full_o         (dst_full_s),
    .almost_empty_o (dst_aempty_s),
    .almost_full_o  (dst_afull_s)
  );

  // Next state of the destination transfer FSM and its word counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_base_s = (state_q == DST_IDLE) ? CNT_ZERO : cnt_q;
    cnt_inc_s  = (&cnt_base_s) ? cnt_base_s : (cnt_base_s + CNT_ONE);
    dc_hit_s   = (dc_i != CNT_ZERO) && (cnt_inc_s == dc_i);
    if (m_reset_i) begin
      state_d = DST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        DST_IDLE: begin
          if (dst_pop_ok_s) begin
            cnt_d   = cnt_inc_s;
            state_d = (dst_head_s[DW] || dc_hit_s) ? DST_END : DST_XFER;
          end else begin
            cnt_d   = CNT_ZERO;
            state_d = DST_IDLE;
          end
        end
        DST_XFER: begin
          if (dst_pop_ok_s) begin
            cnt_d   = cnt_inc_s;
            state_d = (dst_head_s[DW] || dc_hit_s) ? DST_END : DST_XFER;
          end else begin
            cnt_d   = cnt_q;
            state_d = DST_XFER;
          end
        end
        DST_END: begin
          cnt_d   = cnt_q;
          state_d = DST_END;
        end
        default: begin
          cnt_d   = CNT_ZERO;
          state_d = DST_IDLE;
        end
      endcase
    end
    end_d = (state_d == DST_END);
  end

  // FSM registers; ss_end_dst_o is a flop that mirrors the END state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= DST_IDLE;
      cnt_q   <= CNT_ZERO;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
    end
  end

  assign m_src_o              = src_head_s[DW-1:0];
  assign m_src_last_o         = src_head_s[DW];
  assign m_src_empty_o        = src_empty_s;
  assign m_src_almost_empty_o = src_aempty_s;
  assign ss_start_src_o       = (src_level_s < HALF_L);
  assign ss_stop_src_o        = src_afull_s;

  assign m_dst_full_o         = dst_full_s;
  assign m_dst_almost_full_o  = dst_afull_s;
  assign wbs_dat_dst_o        = dst_head_s[DW-1:0];
  // A finished producer may flush a partial block below the half mark.
  assign ss_start_dst_o       = (dst_level_s >= HALF_L) | (~m_endn_i & ~dst_empty_s);
  assign ss_stop_dst_o        = dst_aempty_s;
  assign ss_end_dst_o         = end_q;

`ifdef CHN_FIFO_ERR_EN
  logic [ERR_W-1:0] err_q, err_d;

  // Accumulate dropped pushes and ignored pops until a clear.
  always_comb begin
    err_d = err_q;
    if (m_reset_i) begin
      err_d = {ERR_W{1'b0}};
    end else begin
      err_d[ERR_SRC_OVF] = err_q[ERR_SRC_OVF] | (src_push_s & src_full_s);
      err_d[ERR_SRC_UDF] = err_q[ERR_SRC_UDF] | (src_pop_s & src_empty_s);
      err_d[ERR_DST_OVF] = err_q[ERR_DST_OVF] | (dst_push_s & dst_full_s);
      err_d[ERR_DST_UDF] = err_q[ERR_DST_UDF] | (dst_pop_req_s & dst_empty_s);
    end
  end

  // Sticky error register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      err_q <= {ERR_W{1'b0}};
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Source full is only consumed by the error logic.
  logic unused_src_full_s;
  assign unused_src_full_s = src_full_s;
`endif

endmodule

// File: tb/tb_chn_fifo_bridge.sv
// tb_chn_fifo_bridge: self-checking bench for chn_fifo_bridge (AW=4).
// A queue-based reference model tracks both FIFOs, the destination transfer
// state and (with CHN_FIFO_ERR_EN) the sticky errors; every clock all
// outputs are compared against it. Directed sequences add explicit
// expectations for the corner cases.
module tb_chn_fifo_bridge;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int CW    = 24;
  localparam int DEPTH = 16;
  localparam int HALF  = 8;
  localparam longint CNT_MAX = (longint'(1) << CW) - 1;
  localparam int M_IDLE = 0;
  localparam int M_XFER = 1;
  localparam int M_END  = 2;

  logic          clk;
  logic          rst_n;
  logic          m_reset_i;
  logic [CW-1:0] dc_i;
  logic          ss_xfer_src_i, ss_last_src_i;
  logic [DW-1:0] wbs_dat_src_i;
  logic          ss_start_src_o, ss_stop_src_o;
  logic          m_src_getn_i;
  logic [DW-1:0] m_src_o;
  logic          m_src_last_o, m_src_empty_o, m_src_almost_empty_o;
  logic          m_dst_putn_i;
  logic [DW-1:0] m_dst_i;
  logic          m_dst_last_i;
  logic          m_dst_full_o, m_dst_almost_full_o;
  logic          m_endn_i;
  logic          ss_xfer_dst_i;
  logic [DW-1:0] wbs_dat_dst_o;
  logic          ss_start_dst_o, ss_stop_dst_o, ss_end_dst_o;
`ifdef CHN_FIFO_ERR_EN
  logic [3:0]    err_o;
  logic [3:0]    m_err;
`endif

  int checks;
  int failures;

  // Reference model state
  logic [DW:0] src_q[$];
  logic [DW:0] dst_q[$];
  int          m_state;
  longint      m_cnt;

  chn_fifo_bridge #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .wb_clk_i             (clk),
    .wb_rst_n_i           (rst_n),
    .m_reset_i            (m_reset_i),
    .dc_i                 (dc_i),
    .ss_xfer_src_i        (ss_xfer_src_i),
    .ss_last_src_i        (ss_last_src_i),
    .wbs_dat_src_i        (wbs_dat_src_i),
    .ss_start_src_o       (ss_start_src_o),
    .ss_stop_src_o        (ss_stop_src_o),
    .m_src_getn_i         (m_src_getn_i),
    .m_src_o              (m_src_o),
    .m_src_last_o         (m_src_last_o),
    .m_src_empty_o        (m_src_empty_o),
    .m_src_almost_empty_o (m_src_almost_empty_o),
    .m_dst_putn_i         (m_dst_putn_i),
    .m_dst_i              (m_dst_i),
    .m_dst_last_i         (m_dst_last_i),
    .m_dst_full_o         (m_dst_full_o),
    .m_dst_almost_full_o  (m_dst_almost_full_o),
    .m_endn_i             (m_endn_i),
    .ss_xfer_dst_i        (ss_xfer_dst_i),
    .wbs_dat_dst_o        (wbs_dat_dst_o),
    .ss_start_dst_o       (ss_start_dst_o),
    .ss_stop_dst_o        (ss_stop_dst_o),
    .ss_end_dst_o         (ss_end_dst_o)
`ifdef CHN_FIFO_ERR_EN
    ,
    .err_o                (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    src_q.delete();
    dst_q.delete();
    m_state = M_IDLE;
    m_cnt   = 0;
`ifdef CHN_FIFO_ERR_EN
    m_err   = 4'b0000;
`endif
  endtask

  // Apply the rules of one clock edge to the reference model.
  task automatic model_step();
    int          sn = src_q.size();
    int          dn = dst_q.size();
    logic        s_push = ss_xfer_src_i;
    logic        s_pop  = !m_src_getn_i;
    logic        d_push = !m_dst_putn_i;
    logic        d_req  = ss_xfer_dst_i && (m_state != M_END);
    logic [DW:0] head;
    if (!rst_n || m_reset_i) begin
      model_clear();
      return;
    end
`ifdef CHN_FIFO_ERR_EN
    if (s_push && sn == DEPTH) m_err[0] = 1'b1;
    if (s_pop && sn == 0)      m_err[1] = 1'b1;
    if (d_push && dn == DEPTH) m_err[2] = 1'b1;
    if (d_req && dn == 0)      m_err[3] = 1'b1;
`endif
    if (s_pop && sn > 0) head = src_q.pop_front();
    if (s_push && sn < DEPTH) src_q.push_back({ss_last_src_i, wbs_dat_src_i});
    if (d_req && dn > 0) begin
      head = dst_q.pop_front();
      if (m_state == M_IDLE) m_cnt = 0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (head[DW] || (dc_i != 0 && m_cnt == longint'(dc_i))) m_state = M_END;
      else m_state = M_XFER;
    end
    if (d_push && dn < DEPTH) dst_q.push_back({m_dst_last_i, m_dst_i});
  endtask

  task automatic compare_all();
    int sn = src_q.size();
    int dn = dst_q.size();
    chk("src_empty",  128'(m_src_empty_o),        128'(sn == 0));
    chk("src_aempty", 128'(m_src_almost_empty_o), 128'(sn <= 1));
    chk("start_src",  128'(ss_start_src_o),       128'(sn < HALF));
    chk("stop_src",   128'(ss_stop_src_o),        128'(sn >= DEPTH - 1));
    if (sn > 0) begin
      chk("src_data", 128'(m_src_o),      128'(src_q[0][DW-1:0]));
      chk("src_last", 128'(m_src_last_o), 128'(src_q[0][DW]));
    end
    chk("dst_full",  128'(m_dst_full_o),        128'(dn == DEPTH));
    chk("dst_afull", 128'(m_dst_almost_full_o), 128'(dn >= DEPTH - 1));
    chk("start_dst", 128'(ss_start_dst_o),      128'(dn >= HALF || (!m_endn_i && dn > 0)));
    chk("stop_dst",  128'(ss_stop_dst_o),       128'(dn <= 1));
    chk("end_dst",   128'(ss_end_dst_o),        128'(m_state == M_END));
    if (dn > 0) chk("dst_data", 128'(wbs_dat_dst_o), 128'(dst_q[0][DW-1:0]));
`ifdef CHN_FIFO_ERR_EN
    chk("err", 128'(err_o), 128'(m_err));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_src_empty"},  128'(m_src_empty_o),        128'(1));
    chk({tag, "_src_aempty"}, 128'(m_src_almost_empty_o), 128'(1));
    chk({tag, "_start_src"},  128'(ss_start_src_o),       128'(1));
    chk({tag, "_stop_src"},   128'(ss_stop_src_o),        128'(0));
    chk({tag, "_dst_full"},   128'(m_dst_full_o),         128'(0));
    chk({tag, "_dst_afull"},  128'(m_dst_almost_full_o),  128'(0));
    chk({tag, "_start_dst"},  128'(ss_start_dst_o),       128'(0));
    chk({tag, "_stop_dst"},   128'(ss_stop_dst_o),        128'(1));
    chk({tag, "_end_dst"},    128'(ss_end_dst_o),         128'(0));
  endtask

  task automatic idle_inputs();
    m_reset_i     = 1'b0;
    ss_xfer_src_i = 1'b0;
    ss_last_src_i = 1'b0;
    wbs_dat_src_i = 64'h0;
    m_src_getn_i  = 1'b1;
    m_dst_putn_i  = 1'b1;
    m_dst_i       = 64'h0;
    m_dst_last_i  = 1'b0;
    m_endn_i      = 1'b1;
    ss_xfer_dst_i = 1'b0;
  endtask

  task automatic soft_clear();
    idle_inputs();
    m_reset_i = 1'b1;
    tick();
    m_reset_i = 1'b0;
  endtask

  // Pop the source FIFO until empty; returns the number of words popped.
  task automatic drain_src(output int n);
    n = 0;
    m_src_getn_i = 1'b0;
    while (!m_src_empty_o && n < 40) begin
      tick();
      n++;
    end
    m_src_getn_i = 1'b1;
  endtask

  typedef struct {
    logic        push;
    logic [63:0] data;
    logic        exp_empty;
    logic        exp_aempty;
    logic        exp_start;
    logic        exp_stop;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int n;
    int lvl;
    checks   = 0;
    failures = 0;
    dc_i     = 24'd0;
    idle_inputs();
    model_clear();

    // Table: 17 pushes into the source FIFO; the 17th must be dropped.
    for (int i = 0; i < 17; i++) begin
      lvl = (i + 1 > 16) ? 16 : i + 1;
      tbl[i] = '{push: 1'b1, data: 64'hA000 + 64'(i), exp_empty: 1'b0,
                 exp_aempty: (lvl <= 1), exp_start: (lvl < 8), exp_stop: (lvl >= 15)};
    end

    rst_n = 1'b0;
    #2;
    check_reset_vals("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      ss_xfer_src_i = tbl[i].push;
      wbs_dat_src_i = tbl[i].data;
      tick();
      chk("tbl_empty",  128'(m_src_empty_o),        128'(tbl[i].exp_empty));
      chk("tbl_aempty", 128'(m_src_almost_empty_o), 128'(tbl[i].exp_aempty));
      chk("tbl_start",  128'(ss_start_src_o),       128'(tbl[i].exp_start));
      chk("tbl_stop",   128'(ss_stop_src_o),        128'(tbl[i].exp_stop));
      chk("tbl_head",   128'(m_src_o),              128'(64'hA000));
    end
    ss_xfer_src_i = 1'b0;
    m_src_getn_i  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("order_data", 128'(m_src_o), 128'(64'hA000 + 64'(k)));
      tick();
    end
    m_src_getn_i = 1'b1;
    chk("drop17_empty", 128'(m_src_empty_o), 128'(1));

    // Simultaneous push and pop at levels 0, 8 and 16.
    soft_clear();
    wbs_dat_src_i = 64'hB0;
    ss_xfer_src_i = 1'b1; m_src_getn_i = 1'b0;
    tick();
    ss_xfer_src_i = 1'b0; m_src_getn_i = 1'b1;
    drain_src(n);
    chk("pp_lvl0", 128'(n), 128'(1));
    for (int k = 0; k < 8; k++) begin
      ss_xfer_src_i = 1'b1; wbs_dat_src_i = 64'hB100 + 64'(k); tick();
    end
    m_src_getn_i = 1'b0; wbs_dat_src_i = 64'hB1FF; tick();
    ss_xfer_src_i = 1'b0; m_src_getn_i = 1'b1;
    drain_src(n);
    chk("pp_lvl8", 128'(n), 128'(8));
    for (int k = 0; k < 16; k++) begin
      ss_xfer_src_i = 1'b1; wbs_dat_src_i = 64'hB200 + 64'(k); tick();
    end
    m_src_getn_i = 1'b0; wbs_dat_src_i = 64'hB2FF; tick();
    ss_xfer_src_i = 1'b0; m_src_getn_i = 1'b1;
    drain_src(n);
    chk("pp_lvl16", 128'(n), 128'(15));

    // dc_i = 5 with 8 words: END after the 5th pop, 6th pop ignored.
    soft_clear();
    dc_i = 24'd5;
    for (int k = 0; k < 8; k++) begin
      m_dst_putn_i = 1'b0; m_dst_i = 64'hD0 + 64'(k); tick();
    end
    m_dst_putn_i  = 1'b1;
    ss_xfer_dst_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("dc5_end", 128'(ss_end_dst_o), 128'(k >= 5));
    end
    ss_xfer_dst_i = 1'b0;
    chk("dc5_head", 128'(wbs_dat_dst_o), 128'(64'hD5));
    chk("dc5_stop", 128'(ss_stop_dst_o), 128'(0));
    for (int k = 0; k < 12; k++) begin
      m_dst_putn_i = 1'b0; m_dst_i = 64'hD100 + 64'(k); tick();
    end
    chk("dc5_lvl15_afull", 128'(m_dst_almost_full_o), 128'(1));
    chk("dc5_lvl15_full",  128'(m_dst_full_o),        128'(0));
    tick();
    m_dst_putn_i = 1'b1;
    chk("dc5_lvl16_full", 128'(m_dst_full_o), 128'(1));

    // dc_i = 0 with last on word 3: END after the 3rd pop, cleared by m_reset_i.
    soft_clear();
    dc_i = 24'd0;
    for (int k = 0; k < 5; k++) begin
      m_dst_putn_i = 1'b0; m_dst_i = 64'hE0 + 64'(k); m_dst_last_i = (k == 2); tick();
    end
    m_dst_putn_i = 1'b1; m_dst_last_i = 1'b0;
    ss_xfer_dst_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("last3_end", 128'(ss_end_dst_o), 128'(k >= 3));
    end
    ss_xfer_dst_i = 1'b0;
    chk("last3_head", 128'(wbs_dat_dst_o), 128'(64'hE3));
    soft_clear();
    chk("mrst_end",   128'(ss_end_dst_o),  128'(0));
    chk("mrst_empty", 128'(ss_stop_dst_o), 128'(1));
    chk("mrst_start", 128'(ss_start_dst_o), 128'(0));

    // Two words with the producer done: start asserted below the half mark.
    for (int k = 0; k < 2; k++) begin
      m_dst_putn_i = 1'b0; m_dst_i = 64'hF0 + 64'(k); tick();
    end
    m_dst_putn_i = 1'b1;
    chk("endn1_start", 128'(ss_start_dst_o), 128'(0));
    m_endn_i = 1'b0;
    tick();
    chk("endn0_start", 128'(ss_start_dst_o), 128'(1));
    m_endn_i = 1'b1;
    soft_clear();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic heavy;
      heavy = ((c / 150) % 2) == 1;
      m_reset_i     = ($urandom_range(63) == 0);
      if (m_reset_i) begin
        case ($urandom_range(3))
          0:       dc_i = 24'd0;
          1:       dc_i = 24'd3;
          2:       dc_i = 24'd7;
          default: dc_i = 24'd12;
        endcase
      end
      ss_xfer_src_i = ($urandom_range(3) < (heavy ? 3 : 1));
      ss_last_src_i = ($urandom_range(7) == 0);
      wbs_dat_src_i = {$urandom, $urandom};
      m_src_getn_i  = !($urandom_range(3) < (heavy ? 1 : 3));
      m_dst_putn_i  = !($urandom_range(3) < (heavy ? 3 : 1));
      m_dst_i       = {$urandom, $urandom};
      m_dst_last_i  = ($urandom_range(15) == 0);
      m_endn_i      = ($urandom_range(3) != 0);
      ss_xfer_dst_i = ($urandom_range(3) < (heavy ? 1 : 3));
      tick();
    end
    soft_clear();

    // Asynchronous reset mid-burst at level 9.
    for (int k = 0; k < 9; k++) begin
      ss_xfer_src_i = 1'b1; wbs_dat_src_i = 64'hC0 + 64'(k);
      m_dst_putn_i  = 1'b0; m_dst_i = 64'hC80 + 64'(k);
      tick();
    end
    chk("burst_start_src", 128'(ss_start_src_o), 128'(0));
    chk("burst_start_dst", 128'(ss_start_dst_o), 128'(1));
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_vals("arst");
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chn_fifo_bridge.md
CHN_FIFO_BRIDGE -- requirements
Module: chn_fifo_bridge

Interface
REQ-001 SHALL have parameter DW, default 64, meaning data width; legal values are multiples of 32.
REQ-002 SHALL have parameter AW, default 4, meaning log2 of FIFO depth; DEPTH = 2**AW, AW >= 2.
REQ-003 SHALL have parameter CW, default 24, meaning transfer word-count width.
REQ-004 SHALL have ports `wb_clk_i` (in, 1, the single clock) and `wb_rst_n_i` (in, 1); reset is asynchronous and active-low.
REQ-005 SHALL have ports `m_reset_i` (in, 1, synchronous soft clear of both FIFOs and the FSM) and `dc_i` (in, CW, destination word count; 0 means unlimited).
REQ-006 SHALL have bus-to-module source ports: `ss_xfer_src_i` (in, 1, push), `ss_last_src_i` (in, 1), `wbs_dat_src_i` (in, DW), `ss_start_src_o` (out, 1), `ss_stop_src_o` (out, 1).
REQ-007 SHALL have source read ports: `m_src_getn_i` (in, 1, active-low pop), `m_src_o` (out, DW), `m_src_last_o` (out, 1), `m_src_empty_o` (out, 1), `m_src_almost_empty_o` (out, 1).
REQ-008 SHALL have destination write ports: `m_dst_putn_i` (in, 1, active-low push), `m_dst_i` (in, DW), `m_dst_last_i` (in, 1), `m_dst_full_o` (out, 1), `m_dst_almost_full_o` (out, 1), `m_endn_i` (in, 1, active-low producer done).
REQ-009 SHALL have module-to-bus ports: `ss_xfer_dst_i` (in, 1, pop), `wbs_dat_dst_o` (out, DW), `ss_start_dst_o` (out, 1), `ss_stop_dst_o` (out, 1), `ss_end_dst_o` (out, 1).

Function
REQ-010 Each FIFO SHALL be first-word-fall-through: the head word and its last flag are valid on the outputs in the same cycle the FIFO is non-empty.
REQ-011 Each FIFO SHALL keep an AW+1-bit level; empty = (level == 0), full = (level == DEPTH), almost_empty = (level <= 1), almost_full = (level >= DEPTH-1).
REQ-012 A push when full SHALL be dropped even with a simultaneous pop; a pop when empty SHALL be ignored; a simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the level unchanged.
REQ-013 Pointers SHALL wrap modulo DEPTH without a gap.
REQ-014 `ss_start_src_o` = (src level < DEPTH/2); `ss_stop_src_o` = src almost_full.
REQ-015 `ss_start_dst_o` = (dst level >= DEPTH/2) OR (`m_endn_i` == 0 AND dst non-empty); `ss_stop_dst_o` = dst almost_empty.
REQ-016 The destination FSM SHALL have states IDLE, XFER and END.
REQ-017 The FSM SHALL move IDLE->XFER on the first accepted dst pop.
REQ-018 The FSM SHALL move to END on an accepted pop whose word carries last, or whose pop brings the word counter to `dc_i` (`dc_i` != 0).
REQ-019 The FSM SHALL move END->IDLE only on `m_reset_i`.
REQ-020 The dst word counter (CW bits) SHALL increment on each accepted pop, clear in IDLE, and saturate at all-ones.
REQ-021 `ss_end_dst_o` SHALL be registered and high exactly while in END; pops in END SHALL be ignored.
REQ-022 `m_reset_i` SHALL clear both levels and pointers and force IDLE in the next cycle, overriding same-cycle pushes and pops.

Reset
REQ-023 On `wb_rst_n_i` low, levels, pointers, counter and FSM (IDLE) SHALL clear asynchronously.
REQ-024 Outputs during reset SHALL be: empties = 1, almost_empties/`ss_stop_dst_o` = 1, fulls/almost_fulls = 0, `ss_start_src_o` = 1, `ss_stop_src_o` = 0, `ss_start_dst_o` = 0, `ss_end_dst_o` = 0.
REQ-025 Memory contents SHALL NOT need reset.

Configuration
REQ-026 With macro `CHN_FIFO_ERR_EN` defined, the block SHALL add output `err_o` [3:0]: sticky {dst underflow, dst overflow, src underflow, src overflow}, set by dropped pushes or ignored pops, cleared by reset or `m_reset_i`.
REQ-027 Without `CHN_FIFO_ERR_EN`, `err_o` SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, default DW/AW/CW constants and the err_o bit indices.
REQ-029 One sub-module `chn_fifo` (parametrised DW+1 wide storage, level, flags) SHALL be instantiated twice.

Verification (AW=4, DEPTH=16)
REQ-030 Scenario: 16 src pushes with no pops -> `m_src_full` internal, `ss_stop_src_o` = 1 at level 15, 17th push dropped, and 16 pops return data in order.
REQ-031 Scenario: push and pop in the same cycle at level 0, 8 and 16 -> levels 1, 8 and 15 respectively.
REQ-032 Scenario: `dc_i` = 5 with 8 dst words -> `ss_end_dst_o` rises the cycle after the 5th pop, and the 6th pop is ignored with the level staying at 3.
REQ-033 Scenario: `dc_i` = 0 with the last flag on word 3 -> END after the 3rd pop; `m_reset_i` -> IDLE, empty, `ss_end_dst_o` = 0.
REQ-034 Scenario: 2 dst words and `m_endn_i` = 0 -> `ss_start_dst_o` = 1 despite level < 8.
REQ-035 Scenario: `wb_rst_n_i` asserted mid-burst at level 9 -> immediate empty and all outputs at reset values.
